// File: rtl/ysyx22041405_lsu_ctrl.sv
// ysyx22041405_lsu_ctrl: load/store sequencer from the MEM stage onto a 64-bit req/gnt/rvalid data bus
module ysyx22041405_lsu_ctrl #(
    parameter int WIDTH = 32,
    parameter int BUS_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [WIDTH-1:0]   ex_addr,
    input  logic [WIDTH-1:0]   ex_wdata,
    input  logic               ex_re,
    input  logic               ex_we,
    input  logic [1:0]         ex_size,
    input  logic               ex_unsigned,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic               stall,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [BUS_W-1:0]   mem_wdata,
    output logic [7:0]         mem_wmask,
    input  logic               mem_rvalid,
    input  logic [BUS_W-1:0]   mem_rdata,
    input  logic               mem_err
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d, rdata_q, rdata_d;
    logic [2:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d, we_q, we_d, err_q, err_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;
    logic [7:0]       mask_q, mask_d;
    logic             bad, nop;
    logic [7:0]       base;
    logic [WIDTH-1:0] sh, ld;

    assign bad  = (ex_size == 2'b11) | (ex_re & ex_we) | (ex_size == 2'b01 & ex_addr[0]) |
                  (ex_size == 2'b10 & ex_addr[1:0] != 2'b00);
    assign nop  = ~ex_re & ~ex_we;
    assign base = ex_size == 2'b00 ? 8'h01 : ex_size == 2'b01 ? 8'h03 : 8'h0F;
    // lane extraction: shift the addressed bytes down to bit 0, then extend by size
    assign sh   = WIDTH'(mem_rdata >> {off_q, 3'b000});
    assign ld   = size_q == 2'b00 ? {{(WIDTH-8){~uns_q & sh[7]}}, sh[7:0]} :
                  size_q == 2'b01 ? {{(WIDTH-16){~uns_q & sh[15]}}, sh[15:0]} : sh;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        if (state_q == IDLE && ex_valid) begin
            addr_d  = {ex_addr[WIDTH-1:3], 3'b000};
            off_d   = ex_addr[2:0];
            size_d  = ex_size;
            uns_d   = ex_unsigned;
            we_d    = ex_we;
            mask_d  = base << ex_addr[2:0];
            wdata_d = ~ex_we ? '0 : ex_size == 2'b00 ? {(BUS_W/8){ex_wdata[7:0]}} :
                      ex_size == 2'b01 ? {(BUS_W/16){ex_wdata[15:0]}} : {(BUS_W/WIDTH){ex_wdata}};
            err_d   = bad;
            rdata_d = '0;
            state_d = (bad | nop) ? DONE : ISSUE;
        end else if (state_q == ISSUE) begin
            state_d = mem_gnt ? WAIT : ISSUE;
        end else if (state_q == WAIT && mem_rvalid) begin
            err_d   = mem_err;
            rdata_d = (we_q | mem_err) ? '0 : ld;
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    assign ex_ready  = (state_q == IDLE) & ~rst;
    assign stall     = (ex_valid & state_q == IDLE) | state_q == ISSUE | state_q == WAIT;
    assign mem_req   = state_q == ISSUE;
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_wmask = mem_we ? mask_q : 8'h00;
    assign rsp_valid = state_q == DONE;
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
endmodule
